pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the IF/ID boundary and front of the pipe.
//  Drives PC and IF/ID write enables, IF/ID and ID/EX flushes.
//  Detects load-use hazards and taken-branch redirects (branch resolved in ID).
//  Arbitrates the single memory refill port between I-cache and D-cache misses;
//  D-cache misses have priority. Freezes the whole pipe while a line fill is in progress.
// PARAMETERS
//  LINE_WORDS  8  words per cache-line refill; power of 2, >= 2
//  WIDX_W      3  width of fill_word; equals log2(LINE_WORDS)
// PORTS
//  clk             in   1       clock
//  rst             in   1       synchronous active-high reset
//  icache_miss     in   1       I-cache miss on the current fetch (level)
//  dcache_miss     in   1       D-cache miss on the current MEM access (level)
//  mem_data_valid  in   1       refill word returned by memory this cycle
//  idex_memread    in   1       instruction in EX is a load
//  idex_rd         in   4       destination register of the EX instruction
//  ifid_rs         in   4       source register 1 of the ID instruction
//  ifid_rt         in   4       source register 2 of the ID instruction
//  branch_taken    in   1       ID resolved a taken branch this cycle
//  pc_wren         out  1       PC register write enable
//  ifid_wren       out  1       IF/ID register write enable
//  ifid_flush      out  1       clear IF/ID instruction (insert NOP)
//  idex_flush      out  1       clear ID/EX control (insert bubble)
//  pipe_stall      out  1       global freeze of ID/EX, EX/MEM, MEM/WB
//  mem_req         out  1       refill in progress on the memory port
//  fill_icache     out  1       current refill targets the I-cache
//  fill_dcache     out  1       current refill targets the D-cache
//  fill_word       out  WIDX_W  index of the word delivered by mem_data_valid
//  fill_done       out  1       one-cycle pulse on the last refill word
//  stall_cnt       out  16      perf: cycles with pc_wren=0
//  flush_cnt       out  16      perf: ifid_flush events
// BEHAVIOUR
//  FSM states: RUN, FILL_D, FILL_I. State and word counter are registered.
//  Hazard outputs are combinational from inputs and state.
//  Reset: state=RUN, counter=0, perf counters=0.
//   While rst=1: pc_wren=ifid_wren=0; all flush, stall and fill outputs = 0.
//  Priority in RUN, evaluated each cycle:
//   1. dcache_miss: freeze the pipe this cycle (pc_wren=ifid_wren=0, pipe_stall=1,
//      no flushes). Next state FILL_D.
//   2. icache_miss: same freeze. Next state FILL_I.
//   3. Load-use: idex_memread and idex_rd!=0 and idex_rd matches ifid_rs or ifid_rt.
//      Response: pc_wren=ifid_wren=0, idex_flush=1, pipe_stall=0. Lasts one cycle.
//      branch_taken is ignored this cycle; ID re-evaluates the branch next cycle.
//   4. branch_taken: pc_wren=ifid_wren=1, ifid_flush=1.
//   5. Otherwise: pc_wren=ifid_wren=1, all others 0.
//  FILL_D / FILL_I:
//   - mem_req=1. fill_dcache or fill_icache =1 respectively.
//   - pc_wren=ifid_wren=0, pipe_stall=1, no flushes.
//   - Each mem_data_valid increments the counter; fill_word = counter value.
//   - On the valid with counter=LINE_WORDS-1: fill_done=1, counter wraps to 0,
//     next state RUN.
//   - Miss inputs are ignored during a fill.
//  Simultaneous I+D miss: D fill first. The I-miss is still high in RUN afterwards,
//   so FILL_I follows with exactly one RUN freeze cycle in between.
//  mem_data_valid in RUN is ignored; no counter change.
//  Caches drop their miss signal the cycle after fill_done. A miss still high in
//   RUN starts a new fill.
//  Reset mid-fill: immediate return to RUN next cycle, counter=0, no fill_done.
// CONFIGURATION
//  HAZ_PERF_EN defined:
//   - stall_cnt increments on every cycle with rst=0 and pc_wren=0.
//   - flush_cnt increments on every cycle with ifid_flush=1.
//   - Both are 16-bit, saturate at 16'hFFFF, and are cleared by rst.
//  HAZ_PERF_EN undefined: stall_cnt and flush_cnt are tied to 16'h0000.
//   The ports remain present.
// TESTING
//  T1 Load-use: idex_memread=1, idex_rd=3, ifid_rs=3, branch_taken=1
//     -> one cycle pc_wren=0, ifid_wren=0, idex_flush=1, ifid_flush=0.
//  T2 R0 exemption: idex_memread=1, idex_rd=0, ifid_rt=0
//     -> no stall, pc_wren=1.
//  T3 Branch: branch_taken=1, no hazard
//     -> ifid_flush=1, pc_wren=1, ifid_wren=1 for that cycle only.
//  T4 D-fill: dcache_miss=1, then 8 mem_data_valid pulses with gaps of 3 idle cycles
//     -> fill_word 0..7 in order, fill_dcache=1 throughout, fill_done on the 8th pulse,
//        RUN on the next cycle.
//  T5 Simultaneous I+D miss -> FILL_D completes, one RUN cycle, then FILL_I.
//     Pulse rst after 4 words of the I fill -> RUN, counter=0, mem_req=0.
//  T6 Perf (HAZ_PERF_EN) -> after T1 then T3, stall_cnt=1 and flush_cnt=1.
//     Force 70000 stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer with shared I/D line-refill arbitration
// Optional perf counters enabled by defining HAZ_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int LINE_WORDS = 8,
    parameter int WIDX_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_miss,
    input  logic              dcache_miss,
    input  logic              mem_data_valid,
    input  logic              idex_memread,
    input  logic [3:0]        idex_rd,
    input  logic [3:0]        ifid_rs,
    input  logic [3:0]        ifid_rt,
    input  logic              branch_taken,
    output logic              pc_wren,
    output logic              ifid_wren,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              pipe_stall,
    output logic              mem_req,
    output logic              fill_icache,
    output logic              fill_dcache,
    output logic [WIDX_W-1:0] fill_word,
    output logic              fill_done,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_FILL_D = 2'd1;
    localparam logic [1:0] ST_FILL_I = 2'd2;

    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(LINE_WORDS - 1);

    logic [1:0]        state_q, state_d;
    logic [WIDX_W-1:0] cnt_q, cnt_d;
    logic              load_use;

    assign load_use = idex_memread && (idex_rd != 4'd0) &&
                      ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_wren     = 1'b0;
        ifid_wren   = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_stall  = 1'b0;
        mem_req     = 1'b0;
        fill_icache = 1'b0;
        fill_dcache = 1'b0;
        fill_word   = '0;
        fill_done   = 1'b0;
        if (rst) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_FILL_D, ST_FILL_I: begin
                    mem_req     = 1'b1;
                    fill_dcache = (state_q == ST_FILL_D);
                    fill_icache = (state_q == ST_FILL_I);
                    pipe_stall  = 1'b1;
                    fill_word   = cnt_q;
                    if (mem_data_valid) begin
                        cnt_d = cnt_q + WIDX_W'(1);
                        if (cnt_q == LAST_WORD) begin
                            fill_done = 1'b1;
                            cnt_d     = '0;
                            state_d   = ST_RUN;
                        end
                    end
                end
                default: begin
                    // D-side wins so the older instruction in MEM completes first
                    if (dcache_miss) begin
                        pipe_stall = 1'b1;
                        state_d    = ST_FILL_D;
                    end else if (icache_miss) begin
                        pipe_stall = 1'b1;
                        state_d    = ST_FILL_I;
                    end else if (load_use) begin
                        idex_flush = 1'b1;
                    end else begin
                        pc_wren    = 1'b1;
                        ifid_wren  = 1'b1;
                        ifid_flush = branch_taken;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZ_PERF_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            if (!pc_wren && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (ifid_flush && (flush_cnt_q != 16'hFFFF))
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 16'h0000;
    assign flush_cnt = 16'h0000;
`endif

endmodule
